int_entry_sequencer: RTL and testbench

Interrupt-entry controller for the single-port data memory and the pipeline latches. It arbitrates the data-memory port between MEM-stage accesses, which arrive from the EX/MEM latch, and its own interrupt-entry sequence. The sequence stalls fetch, drains the pipeline, flushes the latches, pushes PC and CCR onto the stack, reads the interrupt vector and redirects the PC. It sits between the EX/MEM latch outputs, the stack-pointer register and the data memory.

---
 rtl/int_entry_sequencer_pkg.sv | 17 +
 rtl/int_entry_sequencer.sv | 136 +++++++++++++
 tb/tb_int_entry_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_entry_sequencer_pkg.sv
// Shared definitions for the interrupt-entry sequencer: state encoding and parameter defaults.
package int_entry_sequencer_pkg;

    localparam logic [7:0]  VEC_ADDR_DEFAULT = 8'h01;
    localparam int unsigned CCR_W_DEFAULT    = 4;

    // Explicit encodings keep the state values stable for anyone probing the legacy bus.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        FLUSH    = 3'd2,
        PUSH_PC  = 3'd3,
        PUSH_CCR = 3'd4,
        VEC_RD   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/int_entry_sequencer.sv
// Interrupt-entry controller: shares the data-memory port with the MEM stage and runs
// the stall / drain / flush / push PC / push CCR / vector-read entry sequence.
module int_entry_sequencer
    import int_entry_sequencer_pkg::*;
#(
    parameter logic [7:0]  VEC_ADDR = VEC_ADDR_DEFAULT,
    parameter int unsigned CCR_W    = CCR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             int_req,
    input  logic             rti_doneM,
    input  logic             D_mem_wenM,
    input  logic             D_mem_renM,
    input  logic             RET_enM,
    input  logic [7:0]       mem_addrM,
    input  logic [7:0]       mem_wdataM,
    input  logic [7:0]       pc_int,
    input  logic [CCR_W-1:0] ccr_in,
    input  logic [7:0]       sp_in,
    input  logic [7:0]       dmem_rdata,
    output logic [7:0]       dmem_addr,
    output logic [7:0]       dmem_wdata,
    output logic             dmem_wen,
    output logic             dmem_ren,
    output logic             sp_dec,
    output logic             fetch_hold,
    output logic             pipe_flush,
    output logic             pc_load,
    output logic [7:0]       pc_vec,
    output logic             int_busy
);

    seq_state_t state, state_nxt;
    logic       int_en;
    logic       int_pending;
    logic [7:0] pc_cap;
    logic [7:0] ccr_ext;
    logic       mem_busy;
    logic       take_int;

    assign mem_busy = D_mem_wenM | D_mem_renM | RET_enM;
    assign take_int = (state == IDLE) && int_pending;
    assign int_busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (int_pending) state_nxt = DRAIN;
            DRAIN:    if (!mem_busy)   state_nxt = FLUSH;
            FLUSH:    state_nxt = PUSH_PC;
            PUSH_PC:  state_nxt = PUSH_CCR;
            PUSH_CCR: state_nxt = VEC_RD;
            VEC_RD:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Taking the interrupt masks further requests; the clear wins over a same-edge set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            int_en      <= 1'b1;
            int_pending <= 1'b0;
            pc_cap      <= '0;
        end else begin
            state <= state_nxt;
            if (take_int) begin
                int_en      <= 1'b0;
                int_pending <= 1'b0;
            end else begin
                if (rti_doneM)
                    int_en <= 1'b1;
                if (int_req && int_en && (state == IDLE))
                    int_pending <= 1'b1;
            end
            if ((state == DRAIN) && !mem_busy)
                pc_cap <= pc_int;
        end
    end

    always_comb begin
        ccr_ext             = '0;
        ccr_ext[CCR_W-1:0]  = ccr_in;
    end

    always_comb begin
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wen   = 1'b0;
        dmem_ren   = 1'b0;
        sp_dec     = 1'b0;
        fetch_hold = 1'b0;
        pipe_flush = 1'b0;
        pc_load    = 1'b0;
        pc_vec     = '0;
        case (state)
            IDLE, DRAIN: begin
                dmem_addr  = mem_addrM;
                dmem_wdata = mem_wdataM;
                dmem_wen   = D_mem_wenM;
                dmem_ren   = D_mem_renM;
                fetch_hold = (state == DRAIN);
            end
            FLUSH: begin
                pipe_flush = 1'b1;
                fetch_hold = 1'b1;
            end
            PUSH_PC: begin
                dmem_addr  = sp_in;
                dmem_wdata = pc_cap;
                dmem_wen   = 1'b1;
                sp_dec     = 1'b1;
                fetch_hold = 1'b1;
            end
            PUSH_CCR: begin
                dmem_addr  = sp_in;
                dmem_wdata = ccr_ext;
                dmem_wen   = 1'b1;
                sp_dec     = 1'b1;
                fetch_hold = 1'b1;
            end
            VEC_RD: begin
                dmem_addr  = VEC_ADDR;
                dmem_ren   = 1'b1;
                pc_vec     = dmem_rdata;
                pc_load    = 1'b1;
                fetch_hold = 1'b1;
            end
            default: begin
                dmem_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_int_entry_sequencer.sv
// Self-checking bench for int_entry_sequencer: passthrough table, directed entry sequences,
// and randomized traffic compared every cycle against a phase-count reference model.
module tb_int_entry_sequencer;
    import int_entry_sequencer_pkg::*;

    localparam logic [7:0] VEC = 8'h01;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, int_req, rti_doneM, D_mem_wenM, D_mem_renM, RET_enM;
    logic [7:0] mem_addrM, mem_wdataM, pc_int, sp;
    logic [3:0] ccr_in;
    logic [7:0] dmem_rdata, dmem_addr, dmem_wdata, pc_vec;
    logic       dmem_wen, dmem_ren, sp_dec, fetch_hold, pipe_flush, pc_load, int_busy;

    logic [7:0] mem [256];
    assign dmem_rdata = mem[dmem_addr];

    int_entry_sequencer #(.VEC_ADDR(VEC), .CCR_W(4)) dut (
        .clk(clk), .rst(rst), .int_req(int_req), .rti_doneM(rti_doneM),
        .D_mem_wenM(D_mem_wenM), .D_mem_renM(D_mem_renM), .RET_enM(RET_enM),
        .mem_addrM(mem_addrM), .mem_wdataM(mem_wdataM), .pc_int(pc_int),
        .ccr_in(ccr_in), .sp_in(sp), .dmem_rdata(dmem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wen(dmem_wen),
        .dmem_ren(dmem_ren), .sp_dec(sp_dec), .fetch_hold(fetch_hold),
        .pipe_flush(pipe_flush), .pc_load(pc_load), .pc_vec(pc_vec), .int_busy(int_busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: interrupt enable, pending flag, and the step count into the entry sequence
    // (0 = not in a sequence, 1 = waiting for MEM to empty, 2..5 = flush, push, push, vector).
    bit         m_valid = 0;
    bit         m_en, m_pend;
    int         m_ph;
    logic [7:0] m_pc;

    logic [7:0] o_addr, o_wdata, o_vec;
    logic       o_wen, o_ren, o_spd, o_fh, o_fl, o_pl, o_busy;
    int         o_cyc;

    typedef struct {
        logic       wen, ren, ret;
        logic [7:0] addr, wdata;
        logic       e_wen, e_ren, e_fh;
        logic [7:0] e_addr, e_wdata;
    } pt_vec_t;
    pt_vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; int_req = 0; rti_doneM = 0;
        D_mem_wenM = 0; D_mem_renM = 0; RET_enM = 0;
        mem_addrM = '0; mem_wdataM = '0;
    endtask

    task automatic step();
        logic [7:0] e_addr, e_wdata, e_vec;
        logic       e_wen, e_ren, e_spd, e_fh, e_fl, e_pl;
        bit         busy_m, old_en;
        int         nph;
        #2;
        if (m_valid) begin
            e_addr = mem_addrM; e_wdata = mem_wdataM; e_wen = D_mem_wenM; e_ren = D_mem_renM;
            e_spd = 0; e_fh = (m_ph != 0); e_fl = 0; e_pl = 0; e_vec = '0;
            if (m_ph >= 2) begin
                e_addr = '0; e_wdata = '0; e_wen = 0; e_ren = 0;
            end
            if (m_ph == 2) e_fl = 1;
            if (m_ph == 3 || m_ph == 4) begin
                e_addr = sp; e_wen = 1; e_spd = 1;
                e_wdata = (m_ph == 3) ? m_pc : {4'h0, ccr_in};
            end
            if (m_ph == 5) begin
                e_addr = VEC; e_ren = 1; e_pl = 1; e_vec = mem[VEC];
            end
            check("outputs",
                  {1'b0, dmem_addr, dmem_wdata, dmem_wen, dmem_ren, sp_dec, fetch_hold,
                   pipe_flush, pc_load, pc_vec, int_busy},
                  {1'b0, e_addr, e_wdata, e_wen, e_ren, e_spd, e_fh, e_fl, e_pl, e_vec,
                   (m_ph != 0)});
        end
        o_addr = dmem_addr; o_wdata = dmem_wdata; o_wen = dmem_wen; o_ren = dmem_ren;
        o_spd = sp_dec; o_fh = fetch_hold; o_fl = pipe_flush; o_pl = pc_load;
        o_vec = pc_vec; o_busy = int_busy; o_cyc = cyc;
        @(posedge clk);
        if (rst) begin
            m_valid = 1; m_en = 1; m_pend = 0; m_ph = 0; m_pc = '0;
        end else if (m_valid) begin
            busy_m = D_mem_wenM | D_mem_renM | RET_enM;
            old_en = m_en;
            nph = m_ph;
            if (m_ph == 0 && m_pend) nph = 1;
            else if (m_ph == 1 && !busy_m) begin nph = 2; m_pc = pc_int; end
            else if (m_ph >= 2 && m_ph <= 4) nph = m_ph + 1;
            else if (m_ph == 5) nph = 0;
            if (m_ph == 0 && m_pend) begin
                m_en = 0; m_pend = 0;
            end else begin
                if (rti_doneM) m_en = 1;
                if (int_req && old_en && m_ph == 0) m_pend = 1;
            end
            m_ph = nph;
        end
        if (o_wen === 1'b1) mem[o_addr] = o_wdata;
        if (o_spd === 1'b1) sp = sp - 8'd1;
        cyc++;
        #1;
    endtask

    // Steps with current inputs until a pc_load is observed; reports where the landmarks fell.
    task automatic run_seq(input int max, output int fl_cyc, output int pl_cyc,
                           output int spd_n, output logic [7:0] vec);
        fl_cyc = -1; pl_cyc = -1; spd_n = 0; vec = '0;
        for (int i = 0; i < max; i++) begin
            step();
            if (o_fl === 1'b1) fl_cyc = o_cyc;
            if (o_spd === 1'b1) spd_n++;
            if (o_pl === 1'b1) begin
                pl_cyc = o_cyc; vec = o_vec;
                break;
            end
        end
    endtask

    task automatic rti_pulse();
        rti_doneM = 1; step(); rti_doneM = 0;
    endtask

    initial begin
        int fl, pl, spd_n, req_c, rd_n, busy_n, first_busy;
        logic [7:0] vec;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h40, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h40, 8'h5A};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 8'h81, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hC3};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h7E, 8'h11, 1'b0, 1'b0, 1'b0, 8'h7E, 8'h11};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        idle_inputs();
        pc_int = 8'h00; ccr_in = 4'h0; sp = 8'hFF;

        rst = 1; step(); step(); rst = 0;
        mem_addrM = 8'h33; mem_wdataM = 8'h44;
        #2;
        check("reset_state",
              {1'b0, dmem_addr, dmem_wdata, dmem_wen, dmem_ren, sp_dec, fetch_hold,
               pipe_flush, pc_load, pc_vec, int_busy},
              {1'b0, 8'h33, 8'h44, 6'b0, 8'h00, 1'b0});

        for (int i = 0; i < 5; i++) begin
            D_mem_wenM = tbl[i].wen; D_mem_renM = tbl[i].ren; RET_enM = tbl[i].ret;
            mem_addrM = tbl[i].addr; mem_wdataM = tbl[i].wdata;
            step();
            check("passthrough", {o_wen, o_ren, o_fh, o_addr, o_wdata},
                  {tbl[i].e_wen, tbl[i].e_ren, tbl[i].e_fh, tbl[i].e_addr, tbl[i].e_wdata});
        end
        idle_inputs();

        // Clean entry
        sp = 8'hFF; pc_int = 8'h23; ccr_in = 4'b1010;
        mem[VEC] = 8'h80; mem[8'hFF] = 8'h00; mem[8'hFE] = 8'h00;
        int_req = 1; req_c = cyc; step(); int_req = 0;
        run_seq(20, fl, pl, spd_n, vec);
        check("entry_flush_latency", fl - req_c, 3);
        check("entry_vec_latency", pl - fl, 3);
        check("entry_pc_vec", vec, 8'h80);
        check("entry_sp_dec_count", spd_n, 2);
        check("entry_push_pc", mem[8'hFF], 8'h23);
        check("entry_push_ccr", mem[8'hFE], 8'h0A);
        check("entry_sp_final", sp, 8'hFD);
        step();
        check("entry_back_idle", o_busy, 1'b0);

        // Drain wait: MEM read traffic holds the sequence in DRAIN
        rti_pulse();
        int_req = 1; req_c = cyc; step(); int_req = 0;
        D_mem_renM = 1; mem_addrM = 8'h10; rd_n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (o_ren === 1'b1 && o_addr == 8'h10) rd_n++;
        end
        D_mem_renM = 0; mem_addrM = 8'h00;
        run_seq(20, fl, pl, spd_n, vec);
        check("drain_reads_served", rd_n, 3);
        check("drain_flush_latency", fl - req_c, 5);

        // Masking until RTI completes
        int_req = 1; rti_pulse();
        run_seq(20, fl, pl, spd_n, vec);
        check("mask_first_seq", pl >= 0, 1);
        busy_n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_busy !== 1'b0) busy_n++;
        end
        check("mask_ignored", busy_n, 0);
        req_c = cyc; rti_pulse();
        first_busy = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_busy === 1'b1) begin first_busy = o_cyc; break; end
        end
        check("mask_reenable_latency", first_busy - req_c, 3);
        int_req = 0;
        run_seq(20, fl, pl, spd_n, vec);

        // SP wrap
        rti_pulse();
        sp = 8'h00; pc_int = 8'h77; ccr_in = 4'h5;
        int_req = 1; step(); int_req = 0;
        run_seq(20, fl, pl, spd_n, vec);
        check("wrap_push_pc", mem[8'h00], 8'h77);
        check("wrap_push_ccr", mem[8'hFF], 8'h05);
        check("wrap_sp_final", sp, 8'hFE);
        step();

        // Reset while pushing CCR
        rti_pulse();
        int_req = 1; step(); int_req = 0;
        for (int i = 0; i < 20 && m_ph != 4; i++) step();
        check("rst_reached_push_ccr", o_spd & o_wen, 1'b1);
        rst = 1; step(); rst = 0;
        step();
        check("rst_ctrl_outputs", {o_busy, o_fh, o_fl, o_pl, o_spd, o_wen, o_ren}, 7'b0);
        int_req = 1; step(); int_req = 0;
        run_seq(20, fl, pl, spd_n, vec);
        check("rst_int_en_restored", pl >= 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            int_req    = ($urandom_range(0, 7) == 0);
            rti_doneM  = ($urandom_range(0, 19) == 0);
            D_mem_wenM = ($urandom_range(0, 2) == 0);
            D_mem_renM = ($urandom_range(0, 2) == 0);
            RET_enM    = ($urandom_range(0, 3) == 0);
            mem_addrM  = 8'($urandom);
            mem_wdataM = 8'($urandom);
            pc_int     = 8'($urandom);
            ccr_in     = 4'($urandom);
            if (m_ph == 0 && $urandom_range(0, 9) == 0) sp = 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
